// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment display path: segment patterns,
// digit slot indices and the all-off anode value.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned IDX_W = 2;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [IDX_W-1:0] DIG_SEC_ONE = 2'd0;
  localparam logic [IDX_W-1:0] DIG_SEC_TEN = 2'd1;
  localparam logic [IDX_W-1:0] DIG_MIN_ONE = 2'd2;
  localparam logic [IDX_W-1:0] DIG_MIN_TEN = 2'd3;

  localparam logic [AN_W-1:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes go blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (value)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_mux.sv
// Time-multiplexed 4-digit common-anode display driver with guard interval,
// minute/second separator dot and blinking of the pair being adjusted.
module seg7_display_mux
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 8,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BCD_W-1:0] min_ten,
  input  logic [BCD_W-1:0] min_one,
  input  logic [BCD_W-1:0] sec_ten,
  input  logic [BCD_W-1:0] sec_one,
  input  logic             adjust,
  input  logic             minselect,
  input  logic             secselect,
  output logic [AN_W-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [BCNT_W-1:0] bcnt, bcnt_n;
  logic              bphase, bphase_n;
  logic [BCD_W-1:0]  digit_n;
  logic [SEG_W-1:0]  seg_n;
  logic [AN_W-1:0]   an_n;
  logic              dp_n;
  logic              blank_n;

  bcd_to_seg7 u_dec (
    .value (digit_n),
    .seg_c (seg_n)
  );

  // Next-state of the scan and blink counters
  always_comb begin
    cnt_n    = cnt + CNT_W'(1);
    idx_n    = idx;
    bcnt_n   = bcnt + BCNT_W'(1);
    bphase_n = bphase;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = idx + IDX_W'(1);
    end
    if (bcnt == BCNT_LAST) begin
      bcnt_n   = '0;
      bphase_n = ~bphase;
    end
  end

  // Outputs derive from next-state so they line up with the registered counters
  always_comb begin
    digit_n = sec_one;
    case (idx_n)
      DIG_SEC_ONE: digit_n = sec_one;
      DIG_SEC_TEN: digit_n = sec_ten;
      DIG_MIN_ONE: digit_n = min_one;
      DIG_MIN_TEN: digit_n = min_ten;
      default:     digit_n = sec_one;
    endcase

    blank_n = adjust && bphase_n && (idx_n[1] ? minselect : secselect);

    an_n = AN_OFF;
    if ((cnt_n >= CNT_GUARD) && !blank_n) an_n[idx_n] = 1'b0;

    dp_n = !((idx_n == DIG_MIN_ONE) && !an_n[DIG_MIN_ONE]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      bcnt   <= '0;
      bphase <= 1'b0;
      an     <= AN_OFF;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
    end else begin
      cnt    <= cnt_n;
      idx    <= idx_n;
      bcnt   <= bcnt_n;
      bphase <= bphase_n;
      an     <= an_n;
      seg    <= seg_n;
      dp     <= dp_n;
    end
  end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Self-checking bench for seg7_display_mux using a cycle-count reference model.
module tb_seg7_display_mux;

  localparam int unsigned RD = 4;
  localparam int unsigned GD = 1;
  localparam int unsigned BD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] min_ten = 4'd0, min_one = 4'd0, sec_ten = 4'd0, sec_one = 4'd0;
  logic       adjust = 1'b0, minselect = 1'b0, secselect = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;
  int k = 0;
  logic [6:0] tbl [16];

  seg7_display_mux #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
    .adjust(adjust), .minselect(minselect), .secselect(secselect),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // k counts edges since the registers were last cleared by reset
  task automatic step();
    @(posedge clk);
    if (reset) k = 0;
    else k = k + 1;
    #1;
  endtask

  // Expected outputs after k released edges, from the slot/blink arithmetic
  task automatic model(output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int c, i, b;
    logic [3:0] v;
    logic blank;
    c = k % RD;
    i = (k / RD) % 4;
    b = (k / BD) % 2;
    case (i)
      0: v = sec_one;
      1: v = sec_ten;
      2: v = min_one;
      default: v = min_ten;
    endcase
    blank = adjust && (b == 1) && ((i >= 2) ? minselect : secselect);
    ea = 4'b1111;
    if (c >= GD && !blank) ea = ~(4'b0001 << i);
    es = tbl[v];
    ed = !(i == 2 && ea == 4'b1011);
  endtask

  task automatic randomize_digits();
    min_ten = 4'($urandom_range(0, 15));
    min_one = 4'($urandom_range(0, 15));
    sec_ten = 4'($urandom_range(0, 15));
    sec_one = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      randomize_digits();
      adjust = 1'($urandom); minselect = 1'($urandom); secselect = 1'($urandom);
      step();
      tests++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
        fails++;
        $display("FAIL reset cyc%0d: an=%b seg=%b dp=%b want 1111 1111111 1", n, an, seg, dp);
      end
    end
    adjust = 1'b0;
    reset = 1'b0;
    tests++;
    if (an !== 4'b1111) begin
      fails++;
      $display("FAIL reset_release_guard: an=%b want 1111", an);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea; logic [6:0] es; logic ed;
    reset = 1'b1; step(); reset = 1'b0;
    min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd3; sec_one = 4'd4;
    adjust = 1'b0;
    for (int n = 0; n < 32; n++) begin
      step();
      model(ea, es, ed);
      tests++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        fails++;
        $display("FAIL scan k=%0d: an=%b seg=%b dp=%b want %b %b %b", k, an, seg, dp, ea, es, ed);
      end
    end
  endtask

  task automatic test_decode();
    for (int v = 0; v < 16; v++) begin
      reset = 1'b1; step(); reset = 1'b0;
      sec_one = 4'(v);
      step();
      tests++;
      if ({an, seg} !== {4'b1110, tbl[v]}) begin
        fails++;
        $display("FAIL decode v=%0d: an=%b seg=%b want 1110 %b", v, an, seg, tbl[v]);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ea; logic [6:0] es; logic ed;
    reset = 1'b1; step(); reset = 1'b0;
    randomize_digits();
    for (int n = 0; n < 96; n++) begin
      adjust = (n < 64);
      minselect = (n < 32) ? 1'b1 : 1'($urandom);
      secselect = (n < 32) ? 1'b0 : 1'($urandom);
      step();
      model(ea, es, ed);
      tests++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        fails++;
        $display("FAIL blink k=%0d: an=%b seg=%b dp=%b want %b %b %b", k, an, seg, dp, ea, es, ed);
      end
    end
    adjust = 1'b0; minselect = 1'b0; secselect = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea; logic [6:0] es; logic ed;
    reset = 1'b1; step(); reset = 1'b0;
    randomize_digits();
    while (k < 10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    for (int n = 0; n < 12; n++) begin
      step();
      model(ea, es, ed);
      tests++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        fails++;
        $display("FAIL reset_mid_restart k=%0d: an=%b seg=%b dp=%b want %b %b %b", k, an, seg, dp, ea, es, ed);
      end
    end
  endtask

  task automatic test_both_selects();
    reset = 1'b1; step(); reset = 1'b0;
    randomize_digits();
    adjust = 1'b1; minselect = 1'b1; secselect = 1'b1;
    for (int n = 0; n < 32; n++) begin
      step();
      if (((k / BD) % 2) == 1) begin
        tests++;
        if ({an, dp} !== {4'b1111, 1'b1}) begin
          fails++;
          $display("FAIL both_selects k=%0d: an=%b dp=%b want 1111 1", k, an, dp);
        end
      end
    end
    adjust = 1'b0; minselect = 1'b0; secselect = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [6:0] es; logic ed;
    reset = 1'b1; step(); reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (($urandom % 4) == 0) randomize_digits();
      adjust = 1'($urandom); minselect = 1'($urandom); secselect = 1'($urandom);
      step();
      model(ea, es, ed);
      tests++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        fails++;
        $display("FAIL random k=%0d: an=%b seg=%b dp=%b want %b %b %b", k, an, seg, dp, ea, es, ed);
      end
    end
  endtask

  initial begin
    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
    tbl[4] = 7'b0011001; tbl[5] = 7'b0010010; tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
    tbl[8] = 7'b0000000; tbl[9] = 7'b0010000;
    for (int v = 10; v < 16; v++) tbl[v] = 7'b1111111;

    test_reset();
    test_scan();
    test_decode();
    test_blink();
    test_reset_mid();
    test_both_selects();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_display_mux.md
Name: seg7_display_mux

Overview:
- Display-side consumer of the clock counter's four BCD digits (min_ten, min_one, sec_ten, sec_one).
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
- Provides an anti-ghosting guard interval, a minute/second separator dot, and blinking of the digit pair being adjusted.
- Sits between the counter and the board display pins; all outputs are registered.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2.
- GUARD, 8, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- BLINK_DIV, 25000000, clk cycles per blink phase toggle; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- min_ten  in  4  BCD tens of minutes
- min_one  in  4  BCD units of minutes
- sec_ten  in  4  BCD tens of seconds
- sec_one  in  4  BCD units of seconds
- adjust  in  1  enables blinking of the selected pair
- minselect  in  1  selects the minute pair (digits 2, 3) for blinking
- secselect  in  1  selects the second pair (digits 0, 1) for blinking
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit
- seg  out  7  segment cathodes, active-low; seg[0]=a ... seg[6]=g
- dp  out  1  decimal point, active-low

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset state:
  - cnt=0, idx=0, bcnt=0, bphase=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Reset overrides all other activity on the same edge.
- Prescaler cnt (width clog2(REFRESH_DIV)):
  - cnt==REFRESH_DIV-1 -> cnt<=0 and idx<=idx+1, wrapping 3->0.
  - Otherwise cnt<=cnt+1.
- Digit mapping: idx 0=sec_one, 1=sec_ten, 2=min_one, 3=min_ten.
- Blink counter bcnt:
  - bcnt==BLINK_DIV-1 -> bcnt<=0 and bphase toggles.
  - Otherwise bcnt<=bcnt+1.
  - bcnt and bphase run continuously, independent of adjust.
- Output registers: every edge loads an/seg/dp from the next-state values of idx, cnt and bphase, plus the digit inputs present at that edge.
  - Outputs therefore always match the current idx, cnt and bphase registers.
  - Digit input to seg latency is 1 cycle.
- Anode enable: an[k]=0 only when all of the following hold:
  - idx==k
  - cnt>=GUARD
  - not blanked
  - At most one anode is low at any time.
- Blanking:
  - Digit k is blanked when adjust=1, bphase=1, and its pair is selected (k in {0,1} with secselect, or k in {2,3} with minselect).
  - minselect and secselect both high blanks all four digits.
  - adjust=0 disables blanking regardless of the select inputs.
- Decode, seg[6:0] for value v of the current digit:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001.
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000.
  - 10..15 -> 1111111 (blank). The anode still follows the enable rule.
- Decimal point: dp=0 only when idx==2 and an[2]==0; otherwise dp=1.
- Input changes mid-slot are reflected on the next edge. There is no snapshot or tearing protection; the counter updates far slower than one scan.

Decomposition:
- Package seg7_pkg holds:
  - SEG_0 through SEG_9 and SEG_BLANK 7-bit patterns.
  - Digit index constants DIG_SEC_ONE=0, DIG_SEC_TEN=1, DIG_MIN_ONE=2, DIG_MIN_TEN=3.
  - AN_OFF=4'b1111.
- One sub-module: bcd_to_seg7, a combinational 4-bit value to 7-bit active-low pattern decoder using seg7_pkg.
- Top module holds the prescaler, blink counter, digit mux, and output registers.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> an=1111, seg=1111111, dp=1. First release cycle: an=1111 while cnt<GUARD.
- Scan (REFRESH_DIV=4, GUARD=1): digits 1,2,3,4 for min_ten..sec_one -> repeating 16-cycle pattern.
  - Slot 0 (an=1110, seg=0011001) for 3 cycles, after 1 cycle of an=1111.
  - Then slot 1 (an=1101, 0110000), slot 2 (an=1011, 0100100, dp=0), slot 3 (an=0111, 1111001).
- Decode sweep: drive sec_one 0..15 and sample during slot 0 -> table patterns for 0..9; seg=1111111 for 10..15 with an=1110.
- Blink (BLINK_DIV=8): adjust=1, minselect=1 -> digits 2 and 3 have an high during bphase=1 (every other 8-cycle window); digits 0 and 1 unaffected. adjust=0 -> no blanking.
- Reset mid-operation: assert reset at idx=2, cnt=2 -> next edge an=1111, idx=0, bphase=0. Scan restarts from slot 0 with the full guard interval.
- Both selects set: adjust=1, minselect=1, secselect=1, bphase=1 -> an=1111 and dp=1 for the entire blink window.
